// File: rtl/divmul_pkg.sv
// rtl/divmul_pkg.sv - shared FSM encoding and default widths for the divider/multiplier pair
package divmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } estado_t;

  localparam int TAMANYO_DEF = 32;
  localparam int T_MOD_DEF   = 5;

endpackage

// File: rtl/complemento_a2.sv
// rtl/complemento_a2.sv - conditional two's complement negation, combinational
module complemento_a2 #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  assign out = neg ? (~in + W'(1)) : in;

endmodule

// File: rtl/multiplicador_algoritmico.sv
// rtl/multiplicador_algoritmico.sv - sequential signed shift-add multiplier; MULT_OVF_EN adds Ovf
module multiplicador_algoritmico
  import divmul_pkg::*;
#(
  parameter int tamanyo = TAMANYO_DEF,
  parameter int t_mod   = T_MOD_DEF
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   Start,
  input  logic [tamanyo-1:0]     A,
  input  logic [tamanyo-1:0]     B,
  output logic [2*tamanyo-1:0]   Prod,
  output logic                   Done
`ifdef MULT_OVF_EN
  ,
  output logic                   Ovf
`endif
);

  estado_t              estado;
  logic                 sign_a;
  logic                 sign_b;
  logic                 c;
  logic [tamanyo-1:0]   m;
  logic [tamanyo-1:0]   q;
  logic [tamanyo-1:0]   accu;
  logic [t_mod-1:0]     cont;
  logic [tamanyo-1:0]   abs_a;
  logic [tamanyo-1:0]   abs_b;
  logic [tamanyo:0]     suma;
  logic [2*tamanyo-1:0] prod_mag;
  logic [2*tamanyo-1:0] prod_sig;

  complemento_a2 #(.W(tamanyo)) u_abs_a (
    .neg (A[tamanyo-1]),
    .in  (A),
    .out (abs_a)
  );

  complemento_a2 #(.W(tamanyo)) u_abs_b (
    .neg (B[tamanyo-1]),
    .in  (B),
    .out (abs_b)
  );

  // Carry kept in the adder so the magnitude of -2^(tamanyo-1) squared never drops a bit
  assign suma     = {c, accu} + {1'b0, (q[0] ? m : '0)};
  assign prod_mag = {accu, q};

  complemento_a2 #(.W(2*tamanyo)) u_sign (
    .neg (sign_a ^ sign_b),
    .in  (prod_mag),
    .out (prod_sig)
  );

`ifdef MULT_OVF_EN
  logic ovf_next;
  assign ovf_next = ~((&prod_sig[2*tamanyo-1:tamanyo-1]) | ~(|prod_sig[2*tamanyo-1:tamanyo-1]));
`endif

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      estado <= IDLE;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      c      <= 1'b0;
      m      <= '0;
      q      <= '0;
      accu   <= '0;
      cont   <= '0;
      Prod   <= '0;
      Done   <= 1'b0;
`ifdef MULT_OVF_EN
      Ovf    <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (estado)
        IDLE: begin
          if (Start) begin
            sign_a <= A[tamanyo-1];
            sign_b <= B[tamanyo-1];
            m      <= abs_a;
            q      <= abs_b;
            accu   <= '0;
            c      <= 1'b0;
            cont   <= t_mod'(tamanyo-1);
            estado <= CALC;
          end
        end
        CALC: begin
          accu <= suma[tamanyo:1];
          q    <= {suma[0], q[tamanyo-1:1]};
          c    <= 1'b0;
          cont <= cont - t_mod'(1);
          if (cont == '0) begin
            estado <= SIGN;
          end
        end
        SIGN: begin
          Prod   <= prod_sig;
          Done   <= 1'b1;
`ifdef MULT_OVF_EN
          Ovf    <= ovf_next;
`endif
          estado <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// tb/tb_multiplicador_algoritmico.sv - self-checking bench, tamanyo=8, random pairs vs arithmetic model
module tb_multiplicador_algoritmico;

  localparam int T = 8;

  logic           CLK;
  logic           RSTa;
  logic           Start;
  logic [T-1:0]   A;
  logic [T-1:0]   B;
  logic [2*T-1:0] Prod;
  logic           Done;
  logic           Ovf;

  int total = 0;
  int bad   = 0;

  multiplicador_algoritmico #(.tamanyo(T), .t_mod(3)) dut (
    .CLK   (CLK),
    .RSTa  (RSTa),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Prod  (Prod),
    .Done  (Done)
`ifdef MULT_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic comprobar(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*T-1:0] ref_mul(input logic [T-1:0] a, input logic [T-1:0] b);
    int r;
    r = int'($signed(a)) * int'($signed(b));
    return (2*T)'(r);
  endfunction

  function automatic logic ref_ovf(input logic [T-1:0] a, input logic [T-1:0] b);
    int r;
    r = int'($signed(a)) * int'($signed(b));
    return (r > 127) || (r < -128);
  endfunction

  // One request; A/B are scrambled after the accepting edge to show they are not reused
  task automatic run_op(input logic [T-1:0] a, input logic [T-1:0] b,
                        output logic [2*T-1:0] p, output int lat, output logic ov);
    @(negedge CLK);
    A = a;
    B = b;
    Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    A = T'($urandom);
    B = T'($urandom);
    for (lat = 1; lat <= 40; lat++) begin
      @(posedge CLK);
      #1;
      if (Done) break;
    end
    comprobar("done_timeout", 64'(lat <= 40), 64'd1);
    p  = Prod;
    ov = Ovf;
  endtask

  logic [T-1:0]   ta [6] = '{8'd7, 8'hF9, 8'hF9, 8'd0,  8'h80, 8'h80};
  logic [T-1:0]   tb [6] = '{8'd6, 8'd6,  8'hFA, 8'hFB, 8'h80, 8'd1};
  logic [2*T-1:0] tp [6] = '{16'h002A, 16'hFFD6, 16'h002A, 16'h0000, 16'h4000, 16'hFF80};

  initial begin
    logic [2*T-1:0] p;
    logic           ov;
    logic [T-1:0]   ra;
    logic [T-1:0]   rb;
    int             lat;
    int             n;
    int             last;
    logic [2*T-1:0] exp_q[$];

    Ovf   = 1'b0;
    RSTa  = 1'b0;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge CLK);
    comprobar("reset_prod", 64'(Prod), 64'd0);
    comprobar("reset_done", 64'(Done), 64'd0);
    RSTa = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], p, lat, ov);
      comprobar($sformatf("dir_prod_%0d", i), 64'(p), 64'(tp[i]));
      comprobar($sformatf("dir_lat_%0d", i), 64'(lat), 64'd9);
`ifdef MULT_OVF_EN
      comprobar($sformatf("dir_ovf_%0d", i), 64'(ov), 64'(ref_ovf(ta[i], tb[i])));
`endif
      @(posedge CLK);
      #1;
      comprobar($sformatf("dir_done_width_%0d", i), 64'(Done), 64'd0);
      comprobar($sformatf("dir_prod_hold_%0d", i), 64'(Prod), 64'(tp[i]));
    end

    // Start held high: one result every tamanyo+2 clocks
    @(negedge CLK);
    A = 8'd5;
    B = 8'hFD;
    Start = 1'b1;
    exp_q.push_back(ref_mul(A, B));
    n = 0;
    last = -1;
    for (int cyc = 0; cyc < 80 && n < 4; cyc++) begin
      @(negedge CLK);
      if (Done) begin
        comprobar("b2b_prod", 64'(Prod), 64'(exp_q.pop_front()));
        if (last >= 0) comprobar("b2b_gap", 64'(cyc - last), 64'd10);
        last = cyc;
        n++;
        if (n < 4) begin
          A = T'($urandom);
          B = T'($urandom);
          exp_q.push_back(ref_mul(A, B));
        end else begin
          Start = 1'b0;
        end
      end
    end
    comprobar("b2b_count", 64'(n), 64'd4);

    // Start pulses while in CALC must not queue a second operation
    @(negedge CLK);
    A = 8'd9;
    B = 8'd9;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (2) @(negedge CLK);
    Start = 1'b1;
    repeat (3) @(negedge CLK);
    Start = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge CLK);
      if (Done) begin
        n++;
        comprobar("ign_prod", 64'(Prod), 64'h51);
      end
    end
    comprobar("ign_done_count", 64'(n), 64'd1);

    // Asynchronous reset in the middle of CALC aborts without a Done
    @(negedge CLK);
    A = 8'd100;
    B = 8'd100;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    RSTa = 1'b0;
    #1;
    comprobar("abort_prod", 64'(Prod), 64'd0);
    comprobar("abort_done", 64'(Done), 64'd0);
    @(negedge CLK);
    RSTa = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge CLK);
      if (Done) n++;
    end
    comprobar("abort_no_done", 64'(n), 64'd0);
    run_op(8'd3, 8'd5, p, lat, ov);
    comprobar("after_abort_prod", 64'(p), 64'h000F);

    for (int i = 0; i < 2000; i++) begin
      ra = T'($urandom);
      rb = T'($urandom);
      if (i < 8) ra = (i[0]) ? 8'h80 : 8'h7F;
      run_op(ra, rb, p, lat, ov);
      comprobar($sformatf("rnd_prod %0h*%0h", ra, rb), 64'(p), 64'(ref_mul(ra, rb)));
`ifdef MULT_OVF_EN
      comprobar($sformatf("rnd_ovf %0h*%0h", ra, rb), 64'(ov), 64'(ref_ovf(ra, rb)));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
